// File: rtl/switch_led_toggle_db.sv
// Multi-channel switch debouncer with per-channel LED toggle.
// Each raw switch is double-synchronised, debounced by a hold counter, and toggles its LED on the chosen edge.
module switch_led_toggle_db #(
    parameter int                NUM_CH          = 4,
    parameter int                DEBOUNCE_LIMIT  = 250000,
    parameter int                TOGGLE_ON_PRESS = 0,
    parameter logic [NUM_CH-1:0] LED_INIT        = '0
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic              i_Clear,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Switch_Db,
    output logic [NUM_CH-1:0] o_Edge_Pulse
);
    localparam int              CW      = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic            QUAL_LVL = (TOGGLE_ON_PRESS != 0);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic          r_sync1, r_sync2, r_stable, r_pulse, r_led;
        logic [CW-1:0] r_count;
        logic          w_commit, w_qual;

        // Commit once the new level has been seen for DEBOUNCE_LIMIT consecutive cycles.
        assign w_commit = (r_sync2 != r_stable) && (r_count == CNT_MAX);
        assign w_qual   = w_commit && (r_sync2 == QUAL_LVL);

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_stable <= 1'b0;
                r_count  <= '0;
                r_pulse  <= 1'b0;
                r_led    <= LED_INIT[g];
            end else begin
                r_sync1 <= i_Switch[g];
                r_sync2 <= r_sync1;
                r_pulse <= w_qual;
                if (r_sync2 == r_stable) begin
                    r_count <= '0;
                end else if (w_commit) begin
                    r_stable <= r_sync2;
                    r_count  <= '0;
                end else begin
                    r_count <= r_count + CW'(1);
                end
                // Clear wins over a toggle landing on the same edge.
                if (i_Clear)
                    r_led <= 1'b0;
                else if (w_qual)
                    r_led <= ~r_led;
            end
        end

        assign o_LED[g]        = r_led;
        assign o_Switch_Db[g]  = r_stable;
        assign o_Edge_Pulse[g] = r_pulse;
    end
endmodule

// File: tb/tb_switch_led_toggle_db.sv
// Directed bench: release-mode, press-mode and LED_INIT=1010 instances with DEBOUNCE_LIMIT=4.
module tb_switch_led_toggle_db;
    logic       clk = 1'b0;
    logic       rstA, rstP, rstC;
    logic [3:0] swA, swP, swC;
    logic       clrA, clrP, clrC;
    logic [3:0] ledA, dbA, plA, ledP, dbP, plP, ledC, dbC, plC;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    switch_led_toggle_db #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .TOGGLE_ON_PRESS(0), .LED_INIT(4'b0000)) dutA (
        .i_Clk(clk), .i_Rst_L(rstA), .i_Switch(swA), .i_Clear(clrA),
        .o_LED(ledA), .o_Switch_Db(dbA), .o_Edge_Pulse(plA));
    switch_led_toggle_db #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .TOGGLE_ON_PRESS(1), .LED_INIT(4'b0000)) dutP (
        .i_Clk(clk), .i_Rst_L(rstP), .i_Switch(swP), .i_Clear(clrP),
        .o_LED(ledP), .o_Switch_Db(dbP), .o_Edge_Pulse(plP));
    switch_led_toggle_db #(.NUM_CH(4), .DEBOUNCE_LIMIT(4), .TOGGLE_ON_PRESS(0), .LED_INIT(4'b1010)) dutC (
        .i_Clk(clk), .i_Rst_L(rstC), .i_Switch(swC), .i_Clear(clrC),
        .o_LED(ledC), .o_Switch_Db(dbC), .o_Edge_Pulse(plC));

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rstA = 1'b0; rstP = 1'b0; rstC = 1'b0;
        swA = '0; swP = '0; swC = '0;
        clrA = 1'b0; clrP = 1'b0; clrC = 1'b0;
        tick(2);
        chk("rstA_led", ledA, 4'b0000);
        chk("rstA_db", dbA, 4'b0000);
        chk("rstA_pl", plA, 4'b0000);
        chk("rstC_led_init", ledC, 4'b1010);
        rstA = 1'b1; rstP = 1'b1; rstC = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_led", ledA, 4'b0000);
            chk("idle_db", dbA, 4'b0000);
            chk("idle_pl", plA, 4'b0000);
        end

        // release mode: press ch0
        swA = 4'b0001;
        tick(5);
        chk("pr0_db_early", dbA, 4'b0000);
        tick();
        chk("pr0_db", dbA, 4'b0001);
        chk("pr0_pl", plA, 4'b0000);
        chk("pr0_led", ledA, 4'b0000);
        // release ch0
        swA = 4'b0000;
        tick(5);
        chk("rl0_db_early", dbA, 4'b0001);
        chk("rl0_led_early", ledA, 4'b0000);
        chk("rl0_pl_early", plA, 4'b0000);
        tick();
        chk("rl0_db", dbA, 4'b0000);
        chk("rl0_pl", plA, 4'b0001);
        chk("rl0_led", ledA, 4'b0001);
        tick();
        chk("rl0_pl_end", plA, 4'b0000);
        chk("rl0_led_hold", ledA, 4'b0001);

        // glitch on ch1: three cycles high drives count to LIMIT-1 without commit
        swA = 4'b0010;
        tick(3);
        swA = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gl_db", dbA, 4'b0000);
            chk("gl_pl", plA, 4'b0000);
            chk("gl_led", ledA, 4'b0001);
        end
        // a fresh press must still take the full latency (count was cleared)
        swA = 4'b0010;
        tick(5);
        chk("pr1_db_early", dbA, 4'b0000);
        tick();
        chk("pr1_db", dbA, 4'b0010);
        swA = 4'b0000;
        tick(6);
        chk("rl1_pl", plA, 4'b0010);
        chk("rl1_led", ledA, 4'b0011);

        // simultaneous release ch0 and ch3
        swA = 4'b1001;
        tick(6);
        chk("pr03_db", dbA, 4'b1001);
        chk("pr03_pl", plA, 4'b0000);
        swA = 4'b0000;
        tick(6);
        chk("rl03_pl", plA, 4'b1001);
        chk("rl03_led", ledA, 4'b1010);
        tick();
        chk("rl03_pl_end", plA, 4'b0000);

        // same again with clear on the commit edge
        swA = 4'b1001;
        tick(6);
        swA = 4'b0000;
        tick(5);
        clrA = 1'b1;
        tick();
        clrA = 1'b0;
        chk("clr_led", ledA, 4'b0000);
        chk("clr_pl", plA, 4'b1001);
        chk("clr_db", dbA, 4'b0000);
        tick();
        chk("clr_pl_end", plA, 4'b0000);
        chk("clr_led_hold", ledA, 4'b0000);

        // press mode on ch2: two full cycles
        swP = 4'b0100;
        tick(5);
        chk("p1_led_early", ledP, 4'b0000);
        tick();
        chk("p1_led", ledP, 4'b0100);
        chk("p1_pl", plP, 4'b0100);
        chk("p1_db", dbP, 4'b0100);
        tick();
        chk("p1_pl_end", plP, 4'b0000);
        swP = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("r1_pl", plP, 4'b0000);
            chk("r1_led", ledP, 4'b0100);
        end
        chk("r1_db", dbP, 4'b0000);
        swP = 4'b0100;
        tick(5);
        chk("p2_led_early", ledP, 4'b0100);
        tick();
        chk("p2_led", ledP, 4'b0000);
        chk("p2_pl", plP, 4'b0100);
        swP = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("r2_pl", plP, 4'b0000);
            chk("r2_led", ledP, 4'b0000);
        end

        // LED_INIT=1010: toggle ch1 off, then reset mid-debounce restores 1010
        swC = 4'b0010;
        tick(6);
        swC = 4'b0000;
        tick(6);
        chk("c_tog_led", ledC, 4'b1000);
        chk("c_tog_pl", plC, 4'b0010);
        swC = 4'b0001;
        tick(4);
        rstC = 1'b0;
        #1;
        chk("c_rst_led", ledC, 4'b1010);
        chk("c_rst_db", dbC, 4'b0000);
        chk("c_rst_pl", plC, 4'b0000);
        tick(2);
        chk("c_rst_led_hold", ledC, 4'b1010);
        rstC = 1'b1;
        // switch held high through reset commits as a press: no toggle in release mode
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("c_post_pl", plC, 4'b0000);
            chk("c_post_led", ledC, 4'b1010);
            if (i == 5) chk("c_post_db_early", dbC, 4'b0000);
            if (i == 6) chk("c_post_db", dbC, 4'b0001);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/switch_led_toggle_db.md
Name: switch_led_toggle_db

Overview:
- Parametrised, multi-channel successor to the single-switch LED toggle.
- Each of NUM_CH raw switch inputs is two-flop synchronised and then debounced with a per-channel counter.
- Each channel's LED register toggles on a selectable debounced edge: release by default, press optionally.
- Sits between board switch pins and LED pins; also exports the debounced levels and one-cycle edge pulses for downstream logic.

Parameters:
- NUM_CH, 4: number of independent switch/LED channels, ≥1.
- DEBOUNCE_LIMIT, 250000: consecutive cycles a new synchronised level must hold before it is accepted, ≥1 (10 ms at 25 MHz).
- TOGGLE_ON_PRESS, 0: 0 = toggle on debounced 1→0 (release); 1 = toggle on debounced 0→1 (press).
- LED_INIT, {NUM_CH{1'b0}}: per-channel reset value of o_LED.

Ports:
- i_Clk  input  1  system clock; all state on rising edge.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_Switch  input  NUM_CH  raw, asynchronous switch levels.
- i_Clear  input  1  synchronous clear of all LED registers.
- o_LED  output  NUM_CH  registered LED toggle state.
- o_Switch_Db  output  NUM_CH  registered debounced switch level.
- o_Edge_Pulse  output  NUM_CH  one-cycle pulse on each qualifying debounced edge.

Behaviour:
- Reset (i_Rst_L=0, asynchronous):
  - sync1, sync2, stable (o_Switch_Db) and count all reset to 0.
  - o_LED resets to LED_INIT; o_Edge_Pulse resets to 0.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-debounce discards the partial count; no toggle occurs.
- Synchroniser, per channel: sync1 <= i_Switch[ch]; sync2 <= sync1.
- Debounce, per channel:
  - Count width is $clog2(DEBOUNCE_LIMIT+1).
  - If sync2 == stable: count <= 0.
  - Else if count == DEBOUNCE_LIMIT-1: commit (stable <= sync2, count <= 0).
  - Else: count <= count+1.
- Glitches:
  - A level that returns to stable before commit resets count to 0; there is no commit, pulse or toggle.
  - Count never exceeds DEBOUNCE_LIMIT-1 and never wraps.
- Qualifying edge:
  - A commit where the new stable value is 0 (TOGGLE_ON_PRESS=0) or 1 (TOGGLE_ON_PRESS=1).
  - A commit of the other polarity updates o_Switch_Db only.
- On a qualifying edge, in the same clock as the commit:
  - o_Edge_Pulse[ch] <= 1 for exactly one cycle.
  - o_LED[ch] <= ~o_LED[ch].
- Latency: an i_Switch change held steady is reflected in o_Switch_Db, o_Edge_Pulse and o_LED after exactly 2+DEBOUNCE_LIMIT rising edges.
- i_Clear:
  - When 1, all o_LED bits <= 0 on that edge.
  - i_Clear has priority over a simultaneous toggle.
  - o_Edge_Pulse and debounce state are unaffected by i_Clear.
- Channels are fully independent: simultaneous commits on several channels each toggle their own LED in the same cycle.
- Switch held at 1 through reset: the debounced 0→1 commit is a press. In release mode this produces no toggle.

Test Plan (DEBOUNCE_LIMIT=4, NUM_CH=4, LED_INIT=0 unless stated):
- Reset then idle: o_LED=0000, o_Switch_Db=0000, o_Edge_Pulse=0000 held for 20 cycles.
- Press and release, release mode:
  - i_Switch[0] 0→1: o_Switch_Db[0]=1 exactly 6 edges later, no pulse, o_LED[0]=0.
  - Then 1→0: o_Switch_Db[0]=0, o_Edge_Pulse[0]=1 for one cycle, o_LED[0]=1, both 6 edges later.
- Glitch rejection: i_Switch[1] high for 3 cycles then low -> o_Switch_Db[1], o_Edge_Pulse[1] and o_LED[1] never change; internal count returns to 0.
- TOGGLE_ON_PRESS=1: two full press/release cycles on ch2 -> o_LED[2] sequence 0→1→0, each change 6 edges after the press; releases cause no pulse.
- Simultaneous events: channels 0 and 3 release on the same cycle -> both pulse and toggle on the same edge. Repeating with i_Clear=1 on that edge -> o_LED=0000 while both pulses still assert.
- Async reset mid-debounce: i_Rst_L low 2 cycles after a change with count=2 -> outputs return to reset values immediately, with no pulse after deassertion; LED_INIT=4'b1010 variant -> o_LED=1010 during reset.
